// File: rtl/ps2_kbd_sequencer_pkg.sv
// rtl/ps2_kbd_sequencer_pkg.sv - shared types and byte constants for the PS/2 keyboard sequencer
package ps2_kbd_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_WAIT_RESP,
        ST_WAIT_BAT,
        ST_READY,
        ST_FAIL
    } seq_state_t;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_LED    = 8'hED;
    localparam logic [7:0] CMD_RATE   = 8'hF3;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;

    localparam logic [7:0] ACK      = 8'hFA;
    localparam logic [7:0] RESEND   = 8'hFE;
    localparam logic [7:0] BAT_OK   = 8'hAA;
    localparam logic [7:0] BAT_FAIL = 8'hFC;

    localparam int TIMER_W = 26;
    localparam int RETRY_W = 2;
    localparam int IDX_W   = 3;

    // Init script occupies indices 0..5, the LED update script 6..7.
    localparam logic [IDX_W-1:0] IDX_BAT_DONE  = 3'd1;
    localparam logic [IDX_W-1:0] IDX_LED_FIRST = 3'd6;

    typedef struct packed {
        logic [7:0] data;
        logic       expect_bat;
        logic       last;
    } rom_entry_t;

    function automatic logic is_scan_byte(input logic [7:0] b);
        return (b != ACK) && (b != RESEND);
    endfunction

endpackage

// File: rtl/ps2_kbd_sequencer_if.sv
// rtl/ps2_kbd_sequencer_if.sv - host-side and client-side signals of the keyboard sequencer
interface ps2_kbd_sequencer_if;
    logic       busy;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       send_req;
    logic [7:0] tx_data;
    logic       led_req;
    logic [2:0] led_mask;
    logic       led_done;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       ready;
    logic       init_fail;

    modport master (
        input  busy, rx_valid, rx_data, rx_error, led_req, led_mask,
        output send_req, tx_data, led_done, scan_valid, scan_code, ready, init_fail
    );

    modport slave (
        output busy, rx_valid, rx_data, rx_error, led_req, led_mask,
        input  send_req, tx_data, led_done, scan_valid, scan_code, ready, init_fail
    );
endinterface

// File: rtl/ps2_cmd_rom.sv
// rtl/ps2_cmd_rom.sv - command script ROM for keyboard bring-up and LED updates
module ps2_cmd_rom
    import ps2_kbd_pkg::*;
#(
    parameter logic [7:0] TYPEMATIC = 8'h20,
    parameter logic [2:0] LED_INIT  = 3'b000
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [2:0]       led_mask,
    output rom_entry_t       entry
);

    always_comb begin
        entry = '{data: 8'h00, expect_bat: 1'b0, last: 1'b0};
        case (idx)
            3'd0: begin
                entry.data       = CMD_RESET;
                entry.expect_bat = 1'b1;
            end
            3'd1: entry.data = CMD_LED;
            3'd2: entry.data = {5'b0, LED_INIT};
            3'd3: entry.data = CMD_RATE;
            3'd4: entry.data = TYPEMATIC;
            3'd5: begin
                entry.data = CMD_ENABLE;
                entry.last = 1'b1;
            end
            3'd6: entry.data = CMD_LED;
            3'd7: begin
                entry.data = {5'b0, led_mask};
                entry.last = 1'b1;
            end
            default: entry.data = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_kbd_sequencer.sv
// rtl/ps2_kbd_sequencer.sv - keyboard bring-up, LED update and scan-code forwarding sequencer
module ps2_kbd_sequencer
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 1_000_000,
    parameter int unsigned BAT_TIMEOUT  = 40_000_000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [7:0]  TYPEMATIC    = 8'h20,
    parameter logic [2:0]  LED_INIT     = 3'b000
) (
    input  logic                 clk,
    input  logic                 reset,
    ps2_kbd_sequencer_if.master  bus
);

    localparam logic [TIMER_W-1:0] RESP_LIMIT = TIMER_W'(RESP_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] BAT_LIMIT  = TIMER_W'(BAT_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] BUSY_LIMIT = TIMER_W'(15);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    seq_state_t         state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [RETRY_W-1:0] retry, retry_n;
    logic [TIMER_W-1:0] timer;
    logic               led_pending, led_pending_n;
    logic [2:0]         led_latched, led_latched_n;
    logic [2:0]         seq_mask, seq_mask_n;
    logic               led_seq, led_seq_n;
    logic               retry_evt;

    logic               send_req_n, led_done_n, scan_valid_n, ready_n, init_fail_n;
    logic [7:0]         tx_data_n, scan_code_n;

    rom_entry_t         rom;

    ps2_cmd_rom #(
        .TYPEMATIC (TYPEMATIC),
        .LED_INIT  (LED_INIT)
    ) u_rom (
        .idx      (idx),
        .led_mask (seq_mask),
        .entry    (rom)
    );

    always_comb begin
        state_n       = state;
        idx_n         = idx;
        retry_n       = retry;
        led_pending_n = led_pending;
        led_latched_n = led_latched;
        seq_mask_n    = seq_mask;
        led_seq_n     = led_seq;
        retry_evt     = 1'b0;
        send_req_n    = 1'b0;
        tx_data_n     = bus.tx_data;
        led_done_n    = 1'b0;
        scan_valid_n  = 1'b0;
        scan_code_n   = bus.scan_code;

        case (state)
            ST_BOOT: begin
                idx_n   = '0;
                state_n = ST_SEND;
            end
            ST_SEND: begin
                if (!bus.busy) begin
                    send_req_n = 1'b1;
                    tx_data_n  = rom.data;
                    state_n    = ST_WAIT_BUSY;
                    // First ED of an LED update consumes the request; later ones queue another pass.
                    if (led_seq && idx == IDX_LED_FIRST && retry == '0) begin
                        led_pending_n = 1'b0;
                        seq_mask_n    = led_latched;
                    end
                end
            end
            ST_WAIT_BUSY: begin
                if (bus.busy) begin
                    state_n = ST_WAIT_DONE;
                end else if (timer >= BUSY_LIMIT) begin
                    retry_evt = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.busy) begin
                    state_n = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == ACK) begin
                        retry_n = '0;
                        if (rom.expect_bat) begin
                            state_n = ST_WAIT_BAT;
                        end else if (rom.last) begin
                            state_n    = ST_READY;
                            led_done_n = led_seq;
                            led_seq_n  = 1'b0;
                        end else begin
                            idx_n   = idx + 3'd1;
                            state_n = ST_SEND;
                        end
                    end else begin
                        retry_evt = 1'b1;
                    end
                end else if (bus.rx_error || timer >= RESP_LIMIT) begin
                    retry_evt = 1'b1;
                end
            end
            ST_WAIT_BAT: begin
                if (bus.rx_valid && bus.rx_data == BAT_OK) begin
                    idx_n   = IDX_BAT_DONE;
                    state_n = ST_SEND;
                end else if ((bus.rx_valid && bus.rx_data == BAT_FAIL) || bus.rx_error ||
                             timer >= BAT_LIMIT) begin
                    state_n = ST_FAIL;
                end
            end
            ST_READY: begin
                if (bus.rx_valid && is_scan_byte(bus.rx_data)) begin
                    scan_valid_n = 1'b1;
                    scan_code_n  = bus.rx_data;
                end
                if (led_pending) begin
                    led_seq_n = 1'b1;
                    idx_n     = IDX_LED_FIRST;
                    retry_n   = '0;
                    state_n   = ST_SEND;
                end
            end
            ST_FAIL: state_n = ST_FAIL;
            default: state_n = ST_BOOT;
        endcase

        if (retry_evt) begin
            if (retry >= RETRY_MAX) begin
                state_n = ST_FAIL;
            end else begin
                retry_n = retry + 2'd1;
                state_n = ST_SEND;
            end
        end

        if (bus.led_req) begin
            led_latched_n = bus.led_mask;
            led_pending_n = 1'b1;
        end

        ready_n     = (state_n == ST_READY);
        init_fail_n = bus.init_fail | (state_n == ST_FAIL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_BOOT;
            idx            <= '0;
            retry          <= '0;
            led_pending    <= 1'b0;
            led_latched    <= 3'b000;
            seq_mask       <= 3'b000;
            led_seq        <= 1'b0;
            bus.send_req   <= 1'b0;
            bus.tx_data    <= 8'h00;
            bus.led_done   <= 1'b0;
            bus.scan_valid <= 1'b0;
            bus.scan_code  <= 8'h00;
            bus.ready      <= 1'b0;
            bus.init_fail  <= 1'b0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            retry          <= retry_n;
            led_pending    <= led_pending_n;
            led_latched    <= led_latched_n;
            seq_mask       <= seq_mask_n;
            led_seq        <= led_seq_n;
            bus.send_req   <= send_req_n;
            bus.tx_data    <= tx_data_n;
            bus.led_done   <= led_done_n;
            bus.scan_valid <= scan_valid_n;
            bus.scan_code  <= scan_code_n;
            bus.ready      <= ready_n;
            bus.init_fail  <= init_fail_n;
        end
    end

    // Timer restarts on every state change and saturates rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (state_n != state) begin
            timer <= '0;
        end else if (timer != '1) begin
            timer <= timer + TIMER_W'(1);
        end
    end

endmodule

// File: tb/tb_ps2_kbd_sequencer.sv
// tb/tb_ps2_kbd_sequencer.sv - self-checking bench with keyboard/host emulation and script model
module tb_ps2_kbd_sequencer;
    import ps2_kbd_pkg::*;

    localparam int RESP_T    = 64;
    localparam int BAT_T     = 256;
    localparam int M_NOMINAL = 0;
    localparam int M_RESEND  = 1;
    localparam int M_SILENT  = 2;
    localparam int M_BATFAIL = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    ps2_kbd_sequencer_if bus();

    ps2_kbd_sequencer #(
        .RESP_TIMEOUT (RESP_T),
        .BAT_TIMEOUT  (BAT_T),
        .MAX_RETRY    (3),
        .TYPEMATIC    (8'h20),
        .LED_INIT     (3'b000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         mode = M_NOMINAL;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_scan[$];
    int         exp_led_done = 0;
    int         inj_seq = 0;
    int         inj_ack = 0;
    logic [7:0] inj_byte = 8'h00;
    int         host_phase = 0;

    // Keyboard behaviour per scenario: -1 means no answer at all.
    function automatic int kbd_reply(input int m, input logic [7:0] b, input int n);
        if (m == M_SILENT && b == 8'hED) return -1;
        if (m == M_RESEND && b == 8'hF3 && n == 1) return 8'hFE;
        return 8'hFA;
    endfunction

    function automatic logic [7:0] kbd_bat(input int m);
        return (m == M_BATFAIL) ? 8'hFC : 8'hAA;
    endfunction

    // Expected transmit order from the bring-up rules; returns 1 if READY is reached.
    function automatic bit model_boot(input int m);
        logic [7:0] script [6];
        int occ [256];
        int tries;
        int r;
        bit done;
        script = '{8'hFF, 8'hED, 8'h00, 8'hF3, 8'h20, 8'hF4};
        for (int k = 0; k < 256; k++) occ[k] = 0;
        for (int i = 0; i < 6; i++) begin
            tries = 0;
            done  = 1'b0;
            while (!done) begin
                exp_tx.push_back(script[i]);
                occ[script[i]]++;
                r = kbd_reply(m, script[i], occ[script[i]]);
                if (r == 8'hFA) done = 1'b1;
                else if (tries == 3) return 1'b0;
                else tries++;
            end
            if (i == 0 && kbd_bat(m) != 8'hAA) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 = ready high, 1 = ready low, 2 = init_fail high, 3 = host replying to F3
    task automatic wait_for(input string name, input int which, input int budget);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0: hit = bus.ready;
                1: hit = !bus.ready;
                2: hit = bus.init_fail;
                default: hit = (host_phase == 3) && (exp_tx.size() == 2);
            endcase
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: condition not reached within %0d cycles", name, budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_send_req"},   bus.send_req,   0);
        chk({tag, "_tx_data"},    bus.tx_data,    0);
        chk({tag, "_ready"},      bus.ready,      0);
        chk({tag, "_init_fail"},  bus.init_fail,  0);
        chk({tag, "_scan_code"},  bus.scan_code,  0);
        chk({tag, "_scan_valid"}, bus.scan_valid, 0);
        chk({tag, "_led_done"},   bus.led_done,   0);
    endtask

    task automatic enter_reset(input int m);
        reset = 1'b0;
        mode  = m;
        exp_tx.delete();
        exp_scan.delete();
        exp_led_done = 0;
        cycles(3);
    endtask

    // Host controller + keyboard emulation, stepped once per negedge.
    initial begin
        int         cnt;
        logic [7:0] last_b;
        int         occ [256];
        int         r;
        cnt    = 0;
        r      = 0;
        last_b = 8'h00;
        for (int k = 0; k < 256; k++) occ[k] = 0;
        bus.busy     = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_error = 1'b0;
        forever begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            if (!reset) begin
                bus.busy   = 1'b0;
                host_phase = 0;
                for (int k = 0; k < 256; k++) occ[k] = 0;
            end else begin
                case (host_phase)
                    0: begin
                        if (bus.send_req) begin
                            last_b = bus.tx_data;
                            occ[last_b]++;
                            cnt        = 2;
                            host_phase = 1;
                        end else if (inj_ack != inj_seq) begin
                            bus.rx_valid = 1'b1;
                            bus.rx_data  = inj_byte;
                            inj_ack      = inj_seq;
                        end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            bus.busy   = 1'b1;
                            cnt        = 8;
                            host_phase = 2;
                        end
                    end
                    2: begin
                        cnt--;
                        if (cnt == 0) begin
                            bus.busy = 1'b0;
                            r        = kbd_reply(mode, last_b, occ[last_b]);
                            if (r < 0) host_phase = 0;
                            else begin
                                cnt        = 3;
                                host_phase = 3;
                            end
                        end
                    end
                    3: begin
                        cnt--;
                        if (cnt == 0) begin
                            bus.rx_valid = 1'b1;
                            bus.rx_data  = 8'(r);
                            cnt          = 10;
                            host_phase   = (last_b == 8'hFF && r == 8'hFA) ? 4 : 0;
                        end
                    end
                    default: begin
                        cnt--;
                        if (cnt == 0) begin
                            bus.rx_valid = 1'b1;
                            bus.rx_data  = kbd_bat(mode);
                            host_phase   = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Per-cycle comparison of DUT events against the model's expectation queues.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (bus.send_req) begin
                    chk("send_while_busy", bus.busy, 0);
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_extra: got send of %02h expected no send", bus.tx_data);
                    end else begin
                        chk("tx_byte", bus.tx_data, exp_tx.pop_front());
                    end
                end
                if (bus.scan_valid) begin
                    if (exp_scan.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scan_extra: got scan %02h expected no scan", bus.scan_code);
                    end else begin
                        chk("scan_byte", bus.scan_code, exp_scan.pop_front());
                    end
                end
                if (bus.led_done) begin
                    checks++;
                    if (exp_led_done == 0) begin
                        errors++;
                        $display("FAIL led_done_extra: got led_done=1 expected 0");
                    end else begin
                        exp_led_done--;
                    end
                end
            end
        end
    end

    initial begin
        bit         ok;
        logic [7:0] nominal_lit [6];
        nominal_lit   = '{8'hFF, 8'hED, 8'h00, 8'hF3, 8'h20, 8'hF4};
        bus.led_req   = 1'b0;
        bus.led_mask  = 3'b000;

        // Nominal bring-up
        enter_reset(M_NOMINAL);
        check_reset_outputs("rst0");
        ok = model_boot(M_NOMINAL);
        chk("model_ok_nominal", ok, 1);
        chk("model_len_nominal", exp_tx.size(), 6);
        for (int i = 0; i < 6; i++) chk("model_pin_nominal", exp_tx[i], nominal_lit[i]);
        reset = 1'b1;
        wait_for("boot_ready", 0, 3000);
        chk("boot_txq_empty", exp_tx.size(), 0);
        chk("boot_init_fail", bus.init_fail, 0);

        // Runtime scan forwarding and LED update
        exp_scan.push_back(8'h1C);
        inj_byte = 8'h1C;
        inj_seq++;
        cycles(6);
        chk("scan_code_1c", bus.scan_code, 8'h1C);
        chk("scan_q_empty", exp_scan.size(), 0);
        inj_byte = 8'hFA;
        inj_seq++;
        cycles(6);
        chk("scan_code_hold", bus.scan_code, 8'h1C);
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'h05);
        exp_led_done = 1;
        bus.led_mask = 3'b101;
        bus.led_req  = 1'b1;
        cycles(1);
        bus.led_req  = 1'b0;
        wait_for("led_start", 1, 50);
        wait_for("led_ready", 0, 1000);
        cycles(2);
        chk("led_txq_empty", exp_tx.size(), 0);
        chk("led_done_count", exp_led_done, 0);
        chk("led_ready_back", bus.ready, 1);

        // Single RESEND on F3
        enter_reset(M_RESEND);
        check_reset_outputs("rst1");
        ok = model_boot(M_RESEND);
        chk("model_ok_resend", ok, 1);
        chk("model_len_resend", exp_tx.size(), 7);
        chk("model_pin_resend3", exp_tx[3], 8'hF3);
        chk("model_pin_resend4", exp_tx[4], 8'hF3);
        chk("model_pin_resend5", exp_tx[5], 8'h20);
        reset = 1'b1;
        wait_for("resend_ready", 0, 3000);
        chk("resend_txq_empty", exp_tx.size(), 0);
        chk("resend_init_fail", bus.init_fail, 0);

        // Retry exhaustion on a silent ED
        enter_reset(M_SILENT);
        ok = model_boot(M_SILENT);
        chk("model_ok_silent", ok, 0);
        chk("model_len_silent", exp_tx.size(), 5);
        reset = 1'b1;
        wait_for("exhaust_fail", 2, 3000);
        chk("exhaust_ready", bus.ready, 0);
        cycles(1000);
        chk("exhaust_txq_empty", exp_tx.size(), 0);
        chk("exhaust_sticky", bus.init_fail, 1);

        // BAT failure after ACK of FF
        enter_reset(M_BATFAIL);
        ok = model_boot(M_BATFAIL);
        chk("model_ok_batfail", ok, 0);
        chk("model_len_batfail", exp_tx.size(), 1);
        reset = 1'b1;
        wait_for("bat_fail", 2, 500);
        cycles(200);
        chk("bat_txq_empty", exp_tx.size(), 0);
        chk("bat_ready", bus.ready, 0);

        // Reset while awaiting the response to F3
        enter_reset(M_NOMINAL);
        ok = model_boot(M_NOMINAL);
        reset = 1'b1;
        wait_for("mid_reach_f3", 3, 3000);
        cycles(1);
        reset = 1'b0;
        cycles(2);
        check_reset_outputs("rst_mid");
        exp_tx.delete();
        ok = model_boot(M_NOMINAL);
        chk("mid_model_first", exp_tx[0], 8'hFF);
        reset = 1'b1;
        wait_for("mid_ready", 0, 3000);
        chk("mid_txq_empty", exp_tx.size(), 0);
        chk("mid_init_fail", bus.init_fail, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_sequencer.md
Name: ps2_kbd_sequencer

Overview:
Command sequencer that sits between the PS/2 host interface and the rest of the client. After reset it runs the keyboard bring-up script:
- reset the keyboard and wait for the self-test (BAT) result;
- set the LEDs;
- set the typematic rate;
- enable scanning.

In the READY state it forwards scan codes and services runtime LED-update requests. Every command byte goes through an ACK/RESEND/timeout retry loop.

Parameters:
RESP_TIMEOUT, 1_000_000, cycles to wait for a response byte after a send completes (20 ms at 50 MHz)
BAT_TIMEOUT, 40_000_000, cycles to wait for the BAT result after ACK of 0xFF
MAX_RETRY, 3, resends allowed per byte before declaring failure (retry counter width 2 bits)
TYPEMATIC, 8'h20, argument byte sent after 0xF3
LED_INIT, 3'b000, LED mask sent during bring-up

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
busy  in  1  ps2_host transmit in progress
rx_valid  in  1  one-cycle pulse, new byte from keyboard
rx_data  in  8  received byte, valid with rx_valid
rx_error  in  1  one-cycle pulse, parity/framing error on receive
send_req  out  1  one-cycle request to ps2_host to transmit tx_data
tx_data  out  8  byte to transmit; held stable from send_req until busy falls
led_req  in  1  one-cycle request to update LEDs
led_mask  in  3  {caps, num, scroll}, sampled with led_req
led_done  out  1  one-cycle pulse when an LED update has been ACKed
scan_valid  out  1  one-cycle pulse, scan_code valid (READY state only)
scan_code  out  8  forwarded scan byte
ready  out  1  high while in READY
init_fail  out  1  sticky failure flag, cleared only by reset

Behaviour:
- Reset (async, reset=0): state BOOT. All pulses 0; tx_data=0; ready=0; init_fail=0; scan_code=0; retry=0; timer=0; LED-pending flag=0.
- Script ROM (index, byte, expected response):
  - 0: FF → FA, then AA
  - 1: ED → FA
  - 2: {5'b0,LED_INIT} → FA
  - 3: F3 → FA
  - 4: TYPEMATIC → FA
  - 5: F4 → FA
- LED script: ED, {5'b0, latched mask}, both expecting FA.
- States:
  - BOOT: one cycle, go to SEND with index=0.
  - SEND: wait for busy=0. Drive tx_data, pulse send_req once, go to WAIT_BUSY.
  - WAIT_BUSY: busy=1 → WAIT_DONE. If busy is not seen within 16 cycles, count a retry and return to SEND.
  - WAIT_DONE: busy=0 → WAIT_RESP; clear the timer.
  - WAIT_RESP:
    - rx 0xFA: clear retry. If index=0 → WAIT_BAT, else advance index.
    - rx 0xFE, any other byte, rx_error, or timer reaching RESP_TIMEOUT-1: retry++ and go to SEND with the same byte.
    - If retry is already MAX_RETRY on a further retry: → FAIL.
  - WAIT_BAT:
    - rx 0xAA → advance to index 1.
    - rx 0xFC, rx_error, or timer reaching BAT_TIMEOUT-1 → FAIL. No retry.
  - Script end → READY. LED sequence end → READY with a led_done pulse.
  - READY: ready=1.
    - rx_valid with a byte other than FA/FE → scan_valid pulse on the next cycle, scan_code=rx_data.
    - Pending LED request → start the LED sequence (ready=0 during it).
  - FAIL: init_fail=1, ready=0. Stays until reset; all rx ignored.
- LED requests:
  - led_req in any state latches led_mask and sets pending. If a request is already pending, the latest mask wins.
  - pending is cleared when ED is first sent.
  - led_done fires once per completed sequence.
- Scan bytes received outside READY are dropped. They are never forwarded.
- send_req is never asserted while busy=1.
- Timer is 26 bits. It saturates, never wraps, and clears on every state entry.
- rx_valid and the timer limit in the same cycle: the byte takes priority.

Decomposition:
- Package ps2_kbd_pkg: state enum, command constants (CMD_RESET=FF, CMD_LED=ED, CMD_RATE=F3, CMD_ENABLE=F4), response constants (ACK=FA, RESEND=FE, BAT_OK=AA, BAT_FAIL=FC).
- One natural sub-module: ps2_cmd_rom. Combinational index→{byte, expect_bat, last}; covers the init and LED scripts.

Test Plan:
- Nominal boot (RESP_TIMEOUT=64, BAT_TIMEOUT=256): model ACKs every byte, sends AA after FF → tx order FF,ED,00,F3,20,F4; ready=1; init_fail=0.
- Resend: first reply to F3 is FE, then FA → F3 transmitted twice, then 20; retry counter back to 0; ready reached.
- Exhaustion: model never answers ED → ED sent 4 times (1+MAX_RETRY), then init_fail=1, ready=0; no further send_req for 1000 cycles.
- BAT fail: ACK FF then send FC → init_fail=1; no ED sent.
- Runtime: in READY, rx 1C → scan_valid pulse, scan_code=1C; rx FA → no scan_valid. led_req mask=3'b101 → tx ED,05 → led_done one pulse, ready returns to 1.
- Reset mid-operation (reset low during WAIT_RESP of byte 3, then release) → all outputs at reset values; sequence restarts from FF.
